// File: rtl/interrupt_arbiter.sv
// Four-source interrupt arbiter with a three-register bus slave (STATUS, MASK, CTRL)
// and a handshake FSM toward the processor interrupt line.
module interrupt_arbiter #(
  parameter logic [7:0] BaseAddr = 8'hE4
) (
  input  logic       CLK,
  input  logic       RESET,
  inout  wire  [7:0] BUS_DATA,
  input  logic [7:0] BUS_ADDR,
  input  logic       BUS_WE,
  input  logic [3:0] IRQ_RAISE_IN,
  output logic [3:0] IRQ_ACK_OUT,
  output logic       BUS_INTERRUPT_RAISE,
  input  logic       BUS_INTERRUPT_ACK
);

  typedef enum logic [1:0] {IDLE, RAISE, ACKSRC, HOLDOFF} state_t;

  state_t     state;
  logic [1:0] active_id;
  logic [1:0] rr_ptr;
  logic [3:0] mask;
  logic       ctrl_mode;

  logic [3:0] eligible;
  logic [1:0] winner;
  logic [7:0] offset;
  logic       in_range;
  logic [7:0] rdata;
  logic       unused_bus_bits;

  assign eligible        = IRQ_RAISE_IN & mask;
  assign offset          = BUS_ADDR - BaseAddr;
  assign in_range        = (offset < 8'd3);
  assign unused_bus_bits = ^BUS_DATA[7:4];

  // Fixed mode is just a round-robin scan that always starts at index 0.
  always_comb begin
    logic [1:0] base;
    logic [1:0] idx;
    logic       found;
    winner = '0;
    found  = 1'b0;
    base   = ctrl_mode ? rr_ptr : 2'd0;
    idx    = '0;
    for (int unsigned i = 0; i < 4; i++) begin
      idx = base + 2'(i);
      if (!found && eligible[idx]) begin
        winner = idx;
        found  = 1'b1;
      end
    end
  end

  always_comb begin
    rdata = '0;
    unique case (offset[1:0])
      2'd0:    rdata = {eligible, (state != IDLE), 1'b0, active_id};
      2'd1:    rdata = {4'b0000, mask};
      2'd2:    rdata = {7'b0000000, ctrl_mode};
      default: rdata = '0;
    endcase
  end

  assign BUS_DATA = (!BUS_WE && in_range) ? rdata : 'z;

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      mask      <= 4'hF;
      ctrl_mode <= 1'b0;
    end else if (BUS_WE && in_range) begin
      case (offset[1:0])
        2'd1:    mask      <= BUS_DATA[3:0];
        2'd2:    ctrl_mode <= BUS_DATA[0];
        default: ;
      endcase
    end
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state               <= IDLE;
      active_id           <= '0;
      rr_ptr              <= '0;
      BUS_INTERRUPT_RAISE <= 1'b0;
      IRQ_ACK_OUT         <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (eligible != 4'b0000) begin
            state               <= RAISE;
            active_id           <= winner;
            rr_ptr              <= winner + 2'd1;
            BUS_INTERRUPT_RAISE <= 1'b1;
          end
        end
        RAISE: begin
          if (BUS_INTERRUPT_ACK) begin
            state               <= ACKSRC;
            BUS_INTERRUPT_RAISE <= 1'b0;
            IRQ_ACK_OUT         <= 4'b0001 << active_id;
          end
        end
        ACKSRC: begin
          state       <= HOLDOFF;
          IRQ_ACK_OUT <= '0;
        end
        HOLDOFF: begin
          // ACTIVE_ID returns to 0 once idle so STATUS reads clean between grants.
          state     <= IDLE;
          active_id <= '0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
